// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// The overflow signal exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             overflow;
`endif

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
`ifdef SERIAL_ADD_OVF_EN
    , input overflow
`endif
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
`ifdef SERIAL_ADD_OVF_EN
    , output overflow
`endif
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell plus a carry flop, one bit per clock.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_adder_if.slave   bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] aSh_q, aSh_d;
  logic [WIDTH-1:0] bSh_q, bSh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             bitSum;
  logic             bitCarry;
  logic             lastBit;
  logic [WIDTH-1:0] resShift;

  always_comb begin
    bitSum   = aSh_q[0] ^ bSh_q[0] ^ carry_q;
    bitCarry = (aSh_q[0] & bSh_q[0]) | (aSh_q[0] & carry_q) | (bSh_q[0] & carry_q);
    lastBit  = (cnt_q == CW'(WIDTH - 1));
    resShift = res_q >> 1;
    resShift[WIDTH-1] = bitSum;
  end

  // Published result only moves on the completion edge; a new request is
  // accepted in any state except RUN.
  always_comb begin
    state_d = state_q;
    aSh_d   = aSh_q;
    bSh_d   = bSh_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) state_d = RUN;
      end
      RUN: begin
        aSh_d   = aSh_q >> 1;
        bSh_d   = bSh_q >> 1;
        carry_d = bitCarry;
        res_d   = resShift;
        cnt_d   = cnt_q + CW'(1);
        if (lastBit) begin
          sum_d   = resShift;
          cout_d  = bitCarry;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = carry_q ^ bitCarry;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = bus.start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.start && (state_q != RUN)) begin
      aSh_d   = bus.a;
      bSh_d   = bus.b;
      carry_d = bus.cin;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      aSh_q   <= '0;
      bSh_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      aSh_q   <= aSh_d;
      bSh_q   <= bSh_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder: an 8-bit instance for the main
// scenarios and a 1-bit instance swept exhaustively.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8();
  serial_adder_if #(.WIDTH(1)) bus1();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int totalChecks = 0;
  int badChecks   = 0;
  logic [7:0] modelSum = 8'h00;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic signedOvf8(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] s);
    return (a[7] == b[7]) && (s[7] != a[7]);
  endfunction

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic cin);
    @(negedge clk);
    bus8.a = a;
    bus8.b = b;
    bus8.cin = cin;
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
  endtask

  // One full transaction: result held during RUN, busy for 8 cycles, single done pulse.
  task automatic runOp(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic [7:0] expSum, input logic expCout);
    int busyCnt = 0;
    int guard = 0;
    applyStimulus(a, b, cin);
    checkOutput({tag, "_held"}, 32'(bus8.sum), 32'(modelSum));
    while (!bus8.done && guard < 40) begin
      if (bus8.busy) busyCnt++;
      @(negedge clk);
      guard++;
    end
    checkOutput({tag, "_done"}, 32'(bus8.done), 32'd1);
    checkOutput({tag, "_busycycles"}, 32'(busyCnt), 32'd8);
    checkOutput({tag, "_sum"}, 32'(bus8.sum), 32'(expSum));
    checkOutput({tag, "_cout"}, 32'(bus8.cout), 32'(expCout));
`ifdef SERIAL_ADD_OVF_EN
    checkOutput({tag, "_ovf"}, 32'(bus8.overflow), 32'(signedOvf8(a, b, expSum)));
`endif
    modelSum = expSum;
    @(negedge clk);
    checkOutput({tag, "_donepulse"}, 32'(bus8.done), 32'd0);
    checkOutput({tag, "_sumhold"}, 32'(bus8.sum), 32'(expSum));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneCount;
    int guard;
    int k;
    logic [7:0] gotSum;
    logic gotCout;

    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;

    #12;
    checkOutput("rst_busy", 32'(bus8.busy), 32'd0);
    checkOutput("rst_done", 32'(bus8.done), 32'd0);
    checkOutput("rst_sum", 32'(bus8.sum), 32'd0);
    checkOutput("rst_cout", 32'(bus8.cout), 32'd0);
    checkOutput("rst_sum1", 32'(bus1.sum), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    checkOutput("rst_ovf", 32'(bus8.overflow), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] carry out of the MSB");
    runOp("t1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);

    $display("[TB] carry-in and signed overflow");
    runOp("t2", 8'h5A, 8'h25, 1'b1, 8'h80, 1'b0);

    $display("[TB] start while busy is ignored");
    applyStimulus(8'h10, 8'h20, 1'b0);
    repeat (2) @(negedge clk);
    bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    doneCount = 0; gotSum = 8'hEE; gotCout = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (bus8.done) begin
        doneCount++;
        gotSum = bus8.sum;
        gotCout = bus8.cout;
      end
      @(negedge clk);
    end
    checkOutput("t3_donecount", 32'(doneCount), 32'd1);
    checkOutput("t3_sum", 32'(gotSum), 32'h30);
    checkOutput("t3_cout", 32'(gotCout), 32'd0);
    checkOutput("t3_idle", 32'(bus8.busy), 32'd0);
    modelSum = 8'h30;

    $display("[TB] asynchronous reset mid-RUN");
    applyStimulus(8'hAA, 8'h55, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t4_busy", 32'(bus8.busy), 32'd0);
    checkOutput("t4_sum", 32'(bus8.sum), 32'd0);
    checkOutput("t4_cout", 32'(bus8.cout), 32'd0);
    checkOutput("t4_done", 32'(bus8.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    modelSum = 8'h00;
    doneCount = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus8.done) doneCount++;
      @(negedge clk);
    end
    checkOutput("t4_nodone", 32'(doneCount), 32'd0);
    runOp("t4b", 8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0);

    $display("[TB] back-to-back start in the DONE cycle");
    @(negedge clk);
    bus8.a = 8'h33; bus8.b = 8'h11; bus8.cin = 1'b0; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    guard = 0;
    while (!bus8.done && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("t5_done1", 32'(bus8.done), 32'd1);
    checkOutput("t5_sum1", 32'(bus8.sum), 32'h44);
    bus8.a = 8'h01; bus8.b = 8'h01; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    k = 1;
    while (!bus8.done && k < 40) begin
      @(negedge clk);
      k++;
    end
    checkOutput("t5_gap", 32'(k), 32'd9);
    checkOutput("t5_done2", 32'(bus8.done), 32'd1);
    checkOutput("t5_sum2", 32'(bus8.sum), 32'h02);
    checkOutput("t5_cout2", 32'(bus8.cout), 32'd0);
    @(negedge clk);

    $display("[TB] WIDTH=1 exhaustive");
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic [1:0] tot;
      v = 3'(i);
      tot = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      @(negedge clk);
      bus1.a = v[2]; bus1.b = v[1]; bus1.cin = v[0]; bus1.start = 1'b1;
      @(negedge clk);
      bus1.start = 1'b0;
      checkOutput($sformatf("w1_busy_%0d", i), 32'(bus1.busy), 32'd1);
      checkOutput($sformatf("w1_early_%0d", i), 32'(bus1.done), 32'd0);
      @(negedge clk);
      checkOutput($sformatf("w1_done_%0d", i), 32'(bus1.done), 32'd1);
      checkOutput($sformatf("w1_sum_%0d", i), 32'(bus1.sum), 32'(tot[0]));
      checkOutput($sformatf("w1_cout_%0d", i), 32'(bus1.cout), 32'(tot[1]));
`ifdef SERIAL_ADD_OVF_EN
      checkOutput($sformatf("w1_ovf_%0d", i), 32'(bus1.overflow),
                  32'((v[2] == v[1]) && (tot[0] != v[2])));
`endif
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
